// File: rtl/divider_4bit_check.sv
// Shift-add reconstruction of a divider's dividend: a_out = q_in*b_in + r_in, BW compute cycles.
// Optional remainder-range flag enabled by defining DIVIDER_4BIT_CHECK_REMCHK_EN.
module divider_4bit_check #(
    parameter int unsigned QW = 4,
    parameter int unsigned BW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [QW-1:0]       q_in,
    input  logic [BW-1:0]       b_in,
    input  logic [QW-1:0]       r_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [QW+BW:0]      a_out,
    output logic                rem_err
);

    localparam int unsigned OW = QW + BW + 1;
    localparam int unsigned CW = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   acc_q, acc_d;
    logic [OW-1:0]   qsh_q, qsh_d;
    logic [BW-1:0]   bsh_q, bsh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [OW-1:0]   a_out_q, a_out_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            qsh_q       <= '0;
            bsh_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            qsh_q       <= qsh_d;
            bsh_q       <= bsh_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            a_out_q     <= a_out_d;
        end
    end

    // Next-state, shift-add datapath and registered-output next values
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        qsh_d   = qsh_q;
        bsh_d   = bsh_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    acc_d   = OW'(r_in);
                    qsh_d   = OW'(q_in);
                    bsh_d   = b_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Always runs the full BW cycles, even when the divisor is zero
                if (bsh_q[0]) begin
                    acc_d = acc_q + qsh_q;
                end
                qsh_d = qsh_q << 1;
                bsh_d = bsh_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BW - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        // Result is latched once on DONE entry and held until the next one
        a_out_d     = ((state_q == S_RUN) && (state_d == S_DONE)) ? acc_d : a_out_q;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign a_out     = a_out_q;

`ifdef DIVIDER_4BIT_CHECK_REMCHK_EN
    logic rem_pend_q, rem_pend_d;
    logic rem_err_q, rem_err_d;

    // Remainder must be strictly below the divisor; captured at accept, shown in DONE
    always_comb begin
        rem_pend_d = rem_pend_q;
        if ((state_q == S_IDLE) && in_valid && in_ready_q) begin
            rem_pend_d = (OW'(r_in) >= OW'(b_in));
        end
        rem_err_d = (state_d == S_DONE) ? rem_pend_q : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_pend_q <= 1'b0;
            rem_err_q  <= 1'b0;
        end else begin
            rem_pend_q <= rem_pend_d;
            rem_err_q  <= rem_err_d;
        end
    end

    assign rem_err = rem_err_q;
`else
    assign rem_err = 1'b0;
`endif

endmodule

// File: tb/tb_divider_4bit_check.sv
// Directed plus random checks of divider_4bit_check against plain Q*B+R arithmetic.
module tb_divider_4bit_check;

    localparam int unsigned QW = 4;
    localparam int unsigned BW = 2;
    localparam int unsigned OW = QW + BW + 1;
`ifdef DIVIDER_4BIT_CHECK_REMCHK_EN
    localparam bit REMCHK = 1'b1;
`else
    localparam bit REMCHK = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] q_in;
    logic [BW-1:0] b_in;
    logic [QW-1:0] r_in;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] a_out;
    logic          rem_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    divider_4bit_check #(.QW(QW), .BW(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .b_in      (b_in),
        .r_in      (r_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .rem_err   (rem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One transaction: accept, wait for the result, optional stall, then handshake
    task automatic run_op(input int q, input int b, input int r, input int stall);
        int n;
        int exp_a;
        int exp_e;
        exp_a = q * b + r;
        exp_e = (REMCHK && (r >= b)) ? 1 : 0;
        in_valid = 1'b1;
        q_in = QW'(q);
        b_in = BW'(b);
        r_in = QW'(r);
        chk("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        q_in = ~q_in;
        b_in = ~b_in;
        r_in = ~r_in;
        chk("busy_not_ready", 32'(in_ready), 32'd0);
        chk("no_early_valid", 32'(out_valid), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(BW));
        chk("a_out", 32'(a_out), 32'(exp_a));
        chk("rem_err", 32'(rem_err), 32'(exp_e));
        for (int s = 0; s < stall; s++) begin
            if (s == 1) begin
                in_valid = 1'b1;
                q_in = 4'd1;
                b_in = 2'd1;
                r_in = 4'd1;
            end
            tick();
            in_valid = 1'b0;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_a_out", 32'(a_out), 32'(exp_a));
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handshake_valid_drop", 32'(out_valid), 32'd0);
        chk("handshake_ready_back", 32'(in_ready), 32'd1);
        chk("rem_err_clear", 32'(rem_err), 32'd0);
    endtask

    initial begin
        int qv [16];
        int bv [16];
        int rv [16];
        int last_acc;
        int n;
        int exp_q[$];

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        q_in = '0;
        b_in = '0;
        r_in = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a_out", 32'(a_out), 32'd0);
        chk("rst_rem_err", 32'(rem_err), 32'd0);

        run_op(5, 3, 2, 0);
        run_op(15, 3, 15, 0);
        run_op(9, 0, 7, 0);
        run_op(0, 2, 1, 0);
        run_op(6, 2, 1, 5);

        // Reset on the first RUN edge discards the operation
        in_valid = 1'b1;
        q_in = 4'd4;
        b_in = 2'd3;
        r_in = 4'd0;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_a_out", 32'(a_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_stays_idle", 32'(out_valid), 32'd0);
        end
        run_op(2, 1, 0, 0);

        // Back-to-back random stream with R < B and out_ready held high
        for (int k = 0; k < 16; k++) begin
            bv[k] = int'($urandom_range(1, 3));
            rv[k] = int'($urandom_range(0, bv[k] - 1));
            qv[k] = int'($urandom_range(0, 15));
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        q_in = QW'(qv[0]);
        b_in = BW'(bv[0]);
        r_in = QW'(rv[0]);
        last_acc = 0;
        for (int k = 0; k < 16; k++) begin
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_ready_seen", 32'(in_ready), 32'd1);
            tick();
            exp_q.push_back(qv[k] * bv[k] + rv[k]);
            if (k > 0) begin
                chk("b2b_gap", 32'(cyc - last_acc - 1), 32'(BW + 1));
            end
            last_acc = cyc;
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_latency", 32'(n), 32'(BW));
            chk("b2b_a_out", 32'(a_out), 32'(exp_q.pop_front()));
            chk("b2b_rem_err", 32'(rem_err), 32'd0);
            if (k < 15) begin
                q_in = QW'(qv[k + 1]);
                b_in = BW'(bv[k + 1]);
                r_in = QW'(rv[k + 1]);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("b2b_release", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
